multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multi-cycle RV64 datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath mux selects and write enables. Produces the 2-bit `ALUop` that the ALU control decoder turns into the 4-bit ALU operation. Also holds memory accesses until a ready handshake arrives, counts retired instructions, and traps on unsupported opcodes.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock; only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `opcode`  in  7  `instr[6:0]` from the instruction register; sampled in DECODE only.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load qualified by ALU zero (beq).
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request.
- `IRWrite`  out  1  instruction register load.
- `MemtoReg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  ALU operand A: 0 = PC, 1 = register A.
- `ALUSrcB`  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = immediate, 11 = immediate<<1.
- `ALUop`  out  2  00 = add (address or PC arithmetic), 01 = subtract (beq), 10 = R-type (use funct fields), 11 = I-type ALU.
- `PCSource`  out  1  PC input select: 0 = ALU result, 1 = ALUOut.
- `state`  out  4  current state encoding, for debug.
- `illegal`  out  1  sticky flag: an unsupported opcode was decoded.
- `retired`  out  CNT_W  number of completed instructions; wraps modulo 2^CNT_W.

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, IMM_EXEC=9, ERROR=10. Codes 11–15 go to FETCH on the next clock.
- Every output not listed for a state is 0.
- **FETCH**
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=0.
  - IRWrite and PCWrite = `mem_ready`. These two are the only Mealy outputs.
  - Stay in FETCH while `mem_ready`=0. Go to DECODE when it is 1.
- **DECODE**
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target goes to ALUOut).
  - Next state by opcode:
    - 0000011 (ld) or 0100011 (sd) → MEM_ADDR
    - 0110011 (R-type) → EXECUTE
    - 0010011 (I-type) → IMM_EXEC
    - 1100011 (beq) → BRANCH
    - any other value → ERROR
  - The opcode is latched internally in DECODE so that the ld/sd split in MEM_ADDR does not depend on `opcode` later.
- **MEM_ADDR**: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next is MEM_READ for ld, MEM_WRITE for sd.
- **MEM_READ**: MemRead=1, IorD=1. Waits on `mem_ready`, then goes to MEM_WB.
- **MEM_WB**: RegWrite=1, MemtoReg=1. Next is FETCH; instruction retires.
- **MEM_WRITE**: MemWrite=1, IorD=1. Waits on `mem_ready`, then goes to FETCH; instruction retires on the `mem_ready` cycle.
- **EXECUTE**: ALUSrcA=1, ALUSrcB=00, ALUop=10. Next is ALU_WB.
- **IMM_EXEC**: ALUSrcA=1, ALUSrcB=10, ALUop=11. Next is ALU_WB.
- **ALU_WB**: RegWrite=1, MemtoReg=0. Next is FETCH; instruction retires.
- **BRANCH**: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=1. Next is FETCH; instruction retires.
- **ERROR**
  - All write enables and memory requests are 0.
  - `illegal`=1. Only reset leaves this state.
- **Counter**: `retired` increments by 1 on each retire event above.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=FETCH, `retired`=0, `illegal`=0.
  - Outputs are FETCH outputs immediately: MemRead=1, ALUSrcB=01, all else 0.
  - PCWrite/IRWrite stay 0 while reset is asserted, whatever `mem_ready` is.
- Reset mid-instruction aborts it with no retire. The next fetch starts on the first clock after `rst_n` rises.
- Minimum cycles per instruction, with `mem_ready`=1 on every request cycle:
  - ld: 5 (F, D, MA, MR, WB)
  - sd: 4 (F, D, MA, MW)
  - R-type: 4
  - I-type: 4
  - beq: 3
- Each cycle `mem_ready`=0 during FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Outputs are held stable throughout the wait.
- `mem_ready` is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.
- All state, latched opcode, `illegal` and `retired` are registered. Outputs other than PCWrite/IRWrite are decoded from the state register only.
- `retired` at all ones wraps to 0 on the next retire.

## Test plan
- **Reset**: assert `rst_n`=0 mid-EXECUTE with `mem_ready`=1 → state=0, MemRead=1, ALUSrcB=01, PCWrite=0, `retired`=0, all asynchronously, before the next clock.
- **R-type**: opcode=0110011, `mem_ready`=1 → state sequence 0,1,6,7,0. ALUop=10 in EXECUTE, RegWrite=1 only in ALU_WB, `retired` 0→1 after 4 clocks.
- **ld with wait states**: opcode=0000011, `mem_ready`=0 for 3 cycles in MEM_READ → sequence 0,1,2,3,3,3,3,4,0 (8 cycles). MemtoReg=1 in MEM_WB, `retired`=1.
- **sd then beq back-to-back**: sequence 0,1,2,5,0,1,8,0. MemWrite=1 only in state 5. In BRANCH: ALUop=01, PCWriteCond=1, PCSource=1. `retired`=2.
- **Illegal opcode**: opcode=1111111 in DECODE → state=10, `illegal`=1, all enables 0 for 20 clocks, `retired` unchanged. Reset then restores state=0 and `illegal`=0.
- **Counter wrap**: `CNT_W`=4, run 17 addi instructions (opcode=0010011) → `retired`=1. Each instruction shows ALUop=11 and ALUSrcB=10 in IMM_EXEC.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multi-cycle RV64 datapath
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic             PCSource,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_IMM_EXEC  = 4'd9,
        S_ERROR     = 4'd10
    } state_t;

    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t           r_state;
    state_t           w_next;
    logic [6:0]       r_opcode;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_opcode  <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_opcode <= opcode;
            if (w_next == S_ERROR)
                r_illegal <= 1'b1;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b00;
        PCSource    = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // Gated by rst_n so the Mealy enables stay low during reset
                IRWrite = mem_ready & rst_n;
                PCWrite = mem_ready & rst_n;
                if (mem_ready)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LD, OP_SD: w_next = S_MEM_ADDR;
                    OP_RTYP:      w_next = S_EXECUTE;
                    OP_ITYP:      w_next = S_IMM_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    default:      w_next = S_ERROR;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (r_opcode == OP_SD) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)
                    w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
                w_next  = S_ALU_WB;
            end
            S_IMM_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = 2'b11;
                w_next  = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                w_next      = S_FETCH;
                w_retire    = 1'b1;
            end
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_FETCH;
        endcase
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
